// File: rtl/xtal_osc_ctrl_pkg.sv
// Shared definitions for the 32 kHz crystal oscillator controller:
// FSM state encoding and a counter-width helper.
package xtal_osc_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_RUN     = 3'd3,
        ST_STANDBY = 3'd4,
        ST_WAKE    = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xtal_osc_sync_edge.sv
// Multi-flop synchronizer for the asynchronous oscillator output,
// followed by a rising-edge detector on the synchronized level.
module xtal_osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Shift the raw input through the chain and remember the last stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/xtal_osc_ctrl.sv
// Crystal oscillator controller: sequences enable/standby of the macro,
// enforces startup and standby-exit delays, qualifies the oscillator by
// counting edges with a timeout, and measures its period in system clocks.
module xtal_osc_ctrl
    import xtal_osc_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STARTUP_CYCLES = 1000000,
    parameter int STBY_CYCLES    = 16000,
    parameter int GOOD_EDGES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PER_W          = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               stby_req,
    input  logic               osc_dout,
    output logic               osc_ena,
    output logic               osc_standby,
    output logic               ready,
    output logic               fault,
    output logic [PER_W-1:0]   period,
    output logic               period_valid,
    output logic [STATE_W-1:0] state
);

    // One cycle counter serves both STARTUP and WAKE, sized for the longer.
    localparam int CYC_MAX = (STARTUP_CYCLES > STBY_CYCLES) ? STARTUP_CYCLES : STBY_CYCLES;
    localparam int CYC_W   = cnt_w(CYC_MAX);
    localparam int EDG_W   = cnt_w(GOOD_EDGES);
    localparam int TMO_W   = cnt_w(TIMEOUT_CYCLES);

    localparam logic [CYC_W-1:0] STARTUP_LAST = CYC_W'(STARTUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] STBY_LAST    = CYC_W'(STBY_CYCLES - 1);
    localparam logic [EDG_W-1:0] GOOD_LAST    = EDG_W'(GOOD_EDGES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_MAX      = '1;

    state_t             st, st_nxt;
    logic               rise;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [EDG_W-1:0]   edge_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [PER_W-1:0]   per_cnt;
    logic               per_armed;
    logic               tmo_hit;
    logic               supervise;

    xtal_osc_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (osc_dout),
        .rise   (rise)
    );

    // An edge on the expiry cycle rescues the oscillator.
    assign tmo_hit   = (tmo_cnt == TMO_LAST) && !rise;
    assign supervise = (st == ST_VERIFY) || (st == ST_RUN);
    assign state     = st;

    // Next-state decision; dropping en overrides every other condition.
    always_comb begin
        st_nxt = st;
        if (!en) begin
            st_nxt = ST_OFF;
        end else begin
            case (st)
                ST_OFF:     st_nxt = ST_STARTUP;
                ST_STARTUP: if (cyc_cnt == STARTUP_LAST) st_nxt = ST_VERIFY;
                ST_VERIFY: begin
                    if (rise && edge_cnt == GOOD_LAST) st_nxt = ST_RUN;
                    else if (tmo_hit)                  st_nxt = ST_FAULT;
                end
                ST_RUN: begin
                    if (tmo_hit)       st_nxt = ST_FAULT;
                    else if (stby_req) st_nxt = ST_STANDBY;
                end
                ST_STANDBY: if (!stby_req) st_nxt = ST_WAKE;
                ST_WAKE: begin
                    if (stby_req)                  st_nxt = ST_STANDBY;
                    else if (cyc_cnt == STBY_LAST) st_nxt = ST_VERIFY;
                end
                ST_FAULT:   st_nxt = ST_FAULT;
                default:    st_nxt = ST_OFF;
            endcase
        end
    end

    // State, counters, period measurement and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            st           <= ST_OFF;
            cyc_cnt      <= '0;
            edge_cnt     <= '0;
            tmo_cnt      <= '0;
            per_cnt      <= '0;
            per_armed    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            osc_ena      <= 1'b0;
            osc_standby  <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            st           <= st_nxt;
            period_valid <= 1'b0;

            // Delay counter restarts on every state change.
            if (st_nxt != st)
                cyc_cnt <= '0;
            else if (st == ST_STARTUP || st == ST_WAKE)
                cyc_cnt <= cyc_cnt + 1'b1;

            // Qualification: fresh edge count and timeout on each VERIFY entry.
            if (st_nxt == ST_VERIFY && st != ST_VERIFY) begin
                edge_cnt  <= '0;
                tmo_cnt   <= '0;
                per_armed <= 1'b0;
            end else if (supervise) begin
                if (rise) begin
                    tmo_cnt <= '0;
                    if (st == ST_VERIFY)
                        edge_cnt <= edge_cnt + 1'b1;
                end else if (tmo_cnt != TMO_LAST) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            // Period: first edge only arms the measurement, later edges report it.
            if (supervise && en) begin
                if (rise) begin
                    per_cnt   <= '0;
                    per_armed <= 1'b1;
                    if (per_armed) begin
                        period       <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;
                        period_valid <= 1'b1;
                    end
                end else if (per_cnt != PER_MAX) begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end else begin
                per_cnt <= '0;
            end

            osc_ena     <= (st_nxt != ST_OFF) && (st_nxt != ST_FAULT);
            osc_standby <= (st_nxt == ST_STANDBY);
            ready       <= (st_nxt == ST_RUN);
            if (st_nxt == ST_FAULT)
                fault <= 1'b1;
            else if (st_nxt == ST_OFF)
                fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xtal_osc_ctrl.sv
// Directed bench for xtal_osc_ctrl: nominal start, dead crystal, standby,
// loss in RUN, edge-on-expiry, disable/reset paths and period saturation.
module tb_xtal_osc_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0, stby_req = 1'b0, osc = 1'b0;
    logic       osc_ena, osc_standby, ready, fault, pv;
    logic [7:0] period;
    logic [2:0] state;

    logic       en2 = 1'b0, osc2 = 1'b0;
    logic       osc_ena2, osc_standby2, ready2, fault2, pv2;
    logic [7:0] period2;
    logic [2:0] state2;

    int  total = 0, bad = 0;
    bit  osc_on = 1'b1;
    int  half = 8;

    always #5 clk = ~clk;

    xtal_osc_ctrl #(
        .SYNC_STAGES(2), .STARTUP_CYCLES(20), .STBY_CYCLES(10),
        .GOOD_EDGES(4), .TIMEOUT_CYCLES(50), .PER_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .en(en), .stby_req(stby_req), .osc_dout(osc),
        .osc_ena(osc_ena), .osc_standby(osc_standby), .ready(ready), .fault(fault),
        .period(period), .period_valid(pv), .state(state)
    );

    xtal_osc_ctrl #(
        .SYNC_STAGES(2), .STARTUP_CYCLES(20), .STBY_CYCLES(10),
        .GOOD_EDGES(4), .TIMEOUT_CYCLES(1024), .PER_W(8)
    ) dut_sat (
        .clk(clk), .resetn(resetn), .en(en2), .stby_req(1'b0), .osc_dout(osc2),
        .osc_ena(osc_ena2), .osc_standby(osc_standby2), .ready(ready2), .fault(fault2),
        .period(period2), .period_valid(pv2), .state(state2)
    );

    // Main oscillator model: toggles every `half` clocks while running.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (osc_on) begin
                ph++;
                if (ph >= half) begin osc = ~osc; ph = 0; end
            end
        end
    end

    // Slow oscillator for the saturation check: 600-clock period.
    initial begin
        int ph2 = 0;
        forever begin
            @(posedge clk); #1;
            ph2++;
            if (ph2 >= 300) begin osc2 = ~osc2; ph2 = 0; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_st(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (state !== s && n < max) begin tick(); n++; end
    endtask

    task automatic wait_pv(input int max, output int n);
        n = 0;
        do begin tick(); n++; end while (pv !== 1'b1 && n < max);
    endtask

    int  n;
    bit  rdy_early;
    int  pv_in_verify;
    bit  fault_seen;

    initial begin
        // Reset state
        tick(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_ena", 32'(osc_ena), 0);
        chk("rst_stby", 32'(osc_standby), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_pv", 32'(pv), 0);
        resetn = 1'b1;
        tick();

        // Nominal start with a 16-clock oscillator
        en = 1'b1;
        tick();
        chk("nom_ena", 32'(osc_ena), 1);
        chk("nom_st_first", 32'(state), 1);
        tick(19);
        chk("nom_st_last", 32'(state), 1);
        tick();
        chk("nom_verify", 32'(state), 2);
        rdy_early = 1'b0; pv_in_verify = 0; n = 0;
        while (state == 3'd2 && n < 200) begin
            if (ready) rdy_early = 1'b1;
            if (pv) pv_in_verify++;
            tick(); n++;
        end
        chk("nom_run", 32'(state), 3);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_rdy_early", 32'(rdy_early), 0);
        chk("nom_pv_verify", 32'(pv_in_verify), 2);
        chk("nom_pv_entry", 32'(pv), 1);
        chk("nom_period", 32'(period), 16);
        tick();
        chk("nom_pv_pulse", 32'(pv), 0);
        n = 1;
        while (pv !== 1'b1 && n < 40) begin tick(); n++; end
        chk("nom_pv_gap", 32'(n), 16);
        chk("nom_period2", 32'(period), 16);

        // Standby cycle
        stby_req = 1'b1;
        tick();
        chk("sb_state", 32'(state), 4);
        chk("sb_standby", 32'(osc_standby), 1);
        chk("sb_ena", 32'(osc_ena), 1);
        chk("sb_ready", 32'(ready), 0);
        osc_on = 1'b0;
        tick(80);
        chk("sb_no_tmo", 32'(state), 4);
        osc_on = 1'b1;
        stby_req = 1'b0;
        tick();
        chk("wk_state", 32'(state), 5);
        chk("wk_standby", 32'(osc_standby), 0);
        chk("wk_ena", 32'(osc_ena), 1);
        tick(2);
        stby_req = 1'b1;
        tick();
        chk("wk_resb", 32'(state), 4);
        stby_req = 1'b0;
        tick();
        chk("wk_again", 32'(state), 5);
        tick(9);
        chk("wk_last", 32'(state), 5);
        tick();
        chk("wk_verify", 32'(state), 2);
        wait_st(3'd3, 200, n);
        chk("wk_requal", 32'(state), 3);
        chk("wk_ready", 32'(ready), 1);

        // Loss of oscillation in RUN
        wait_pv(40, n);
        chk("loss_pv", 32'(pv), 1);
        osc_on = 1'b0;
        n = 0;
        while (state != 3'd6 && n < 100) begin tick(); n++; end
        chk("loss_delay", 32'(n), 50);
        chk("loss_fault", 32'(fault), 1);
        chk("loss_ena", 32'(osc_ena), 0);
        chk("loss_ready", 32'(ready), 0);
        en = 1'b0;
        tick();
        chk("loss_off", 32'(state), 0);
        chk("loss_fclr", 32'(fault), 0);

        // Edges exactly 50 clocks apart land on the expiry cycle
        half = 25; osc_on = 1'b1;
        en = 1'b1;
        wait_st(3'd3, 400, n);
        chk("exp_run", 32'(state), 3);
        fault_seen = 1'b0;
        repeat (300) begin tick(); if (fault) fault_seen = 1'b1; end
        chk("exp_nofault", 32'(fault_seen), 0);
        chk("exp_state", 32'(state), 3);
        wait_pv(60, n);
        chk("exp_period", 32'(period), 50);

        // Disable during WAKE
        stby_req = 1'b1;
        tick();
        stby_req = 1'b0;
        tick();
        chk("dis_wk_in", 32'(state), 5);
        tick(3);
        en = 1'b0;
        tick();
        chk("dis_wk_st", 32'(state), 0);
        chk("dis_wk_ena", 32'(osc_ena), 0);
        chk("dis_wk_sb", 32'(osc_standby), 0);
        chk("dis_wk_rdy", 32'(ready), 0);

        // Disable during STARTUP
        en = 1'b1;
        tick(5);
        chk("dis_su_in", 32'(state), 1);
        en = 1'b0;
        tick();
        chk("dis_su_st", 32'(state), 0);
        chk("dis_su_ena", 32'(osc_ena), 0);

        // Disable during VERIFY
        en = 1'b1;
        tick(21);
        chk("dis_vf_in", 32'(state), 2);
        en = 1'b0;
        tick();
        chk("dis_vf_st", 32'(state), 0);
        chk("dis_vf_ena", 32'(osc_ena), 0);
        chk("dis_vf_pv", 32'(pv), 0);

        // One-clock reset while running
        en = 1'b1;
        wait_st(3'd3, 400, n);
        chk("rr_run", 32'(state), 3);
        resetn = 1'b0;
        tick();
        chk("rr_state", 32'(state), 0);
        chk("rr_ready", 32'(ready), 0);
        chk("rr_ena", 32'(osc_ena), 0);
        chk("rr_period", 32'(period), 0);
        resetn = 1'b1;
        en = 1'b0;
        tick();

        // Dead crystal: output stuck low
        osc_on = 1'b0; osc = 1'b0;
        tick(4);
        en = 1'b1;
        tick();
        chk("dead_su", 32'(state), 1);
        tick(20);
        chk("dead_vf", 32'(state), 2);
        tick(49);
        chk("dead_vf_last", 32'(state), 2);
        tick();
        chk("dead_fault_st", 32'(state), 6);
        chk("dead_fault", 32'(fault), 1);
        chk("dead_ena", 32'(osc_ena), 0);
        chk("dead_ready", 32'(ready), 0);
        en = 1'b0;
        tick();
        chk("dead_off", 32'(state), 0);
        chk("dead_fclr", 32'(fault), 0);

        // Period saturation with a 600-clock oscillator
        en2 = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pv2 !== 1'b1 && n < 4000);
        chk("sat_pv", 32'(pv2), 1);
        chk("sat_period", 32'(period2), 255);
        chk("sat_fault", 32'(fault2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
